// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
//   NREQ        : number of requesters (fixed at 8)
//   IDXW        : width of a requester index (3 bits)
//   arb_state_e : arbiter FSM states, 2-bit encoding
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/grant_decoder.sv
// 3-to-8 one-hot decoder for the arbiter grant vector.
// Ports:
//   idx    in  [IDXW-1:0] binary owner index
//   en     in  1          grant active; output is all zero when low
//   onehot out [NREQ-1:0] bit idx set when en=1, otherwise zero
module grant_decoder
  import arb_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] onehot
);

  // Decode the owner index into a single set bit, gated by the enable.
  always_comb begin
    onehot = {NREQ{1'b0}};
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// The owner keeps the grant until it drops its request; the rotating
// priority pointer only moves on release, so a waiting requester is
// always served before the previous owner can win again.
// Optional build macro ARB_TIMEOUT_EN adds a hold counter that forces a
// release after HOLD_MAX consecutive grant cycles.
// Ports:
//   Clock       in  1  rising-edge clock
//   Resetn      in  1  asynchronous active-low reset
//   Req         in  8  level-held request per requester
//   Grant       out 8  one-hot owner vector, zero when no grant
//   GntIdx      out 3  binary owner index, meaningful while GntValid=1
//   GntValid    out 1  a grant is active
//   TimeoutFlag out 1  one-cycle pulse on a forced release
module rr_arbiter8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = 16
)
`endif
(
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Grant,
  output logic [IDXW-1:0] GntIdx,
  output logic            GntValid,
  output logic            TimeoutFlag
);

  arb_state_e      state_r;
  logic [IDXW-1:0] gnt_idx_r;
  logic            gnt_valid_r;
  logic [IDXW-1:0] ptr_r;
  logic [IDXW-1:0] pick_s;
  logic            force_rel_s;

  // Rotate the request vector so ptr lands on bit 0, take the lowest set
  // bit, then add ptr back (3-bit add wraps 7 -> 0).
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] shifted;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;
    dbl     = {req, req};
    shifted = dbl >> ptr;
    rot     = shifted[NREQ-1:0];
    off     = {IDXW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i[IDXW-1:0];
      end else begin
        off = off;
      end
    end
    return ptr + off;
  endfunction

  assign pick_s = rr_pick(Req, ptr_r);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   HCW       = $clog2(HOLD_MAX);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  logic [HCW-1:0] hold_cnt_r;
  logic           timeout_flag_r;

  assign force_rel_s = (hold_cnt_r == HOLD_LAST);

  // Count consecutive grant cycles; held at zero while idle so it starts
  // from zero on every new grant.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hold_cnt_r <= {HCW{1'b0}};
    end else if (state_r == IDLE) begin
      hold_cnt_r <= {HCW{1'b0}};
    end else if (state_r == GRANT) begin
      hold_cnt_r <= hold_cnt_r + HCW'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Flag only a release caused by the counter; an owner that drops its
  // request on the same edge counts as a normal release.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      timeout_flag_r <= 1'b0;
    end else if ((state_r == GRANT) && Req[gnt_idx_r] && force_rel_s) begin
      timeout_flag_r <= 1'b1;
    end else begin
      timeout_flag_r <= 1'b0;
    end
  end

  assign TimeoutFlag = timeout_flag_r;
`else
  assign force_rel_s = 1'b0;
  assign TimeoutFlag = 1'b0;
`endif

  // Arbiter FSM: choose in IDLE, hold in GRANT, one dead cycle in RELEASE.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= IDLE;
      gnt_idx_r   <= {IDXW{1'b0}};
      gnt_valid_r <= 1'b0;
      ptr_r       <= {IDXW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (|Req) begin
            gnt_idx_r   <= pick_s;
            gnt_valid_r <= 1'b1;
            state_r     <= GRANT;
          end else begin
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          if (!Req[gnt_idx_r] || force_rel_s) begin
            gnt_valid_r <= 1'b0;
            ptr_r       <= gnt_idx_r + 3'd1;
            state_r     <= RELEASE;
          end else begin
            state_r     <= GRANT;
          end
        end
        RELEASE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign GntIdx   = gnt_idx_r;
  assign GntValid = gnt_valid_r;

  grant_decoder u_dec (
    .idx    (gnt_idx_r),
    .en     (gnt_valid_r),
    .onehot (Grant)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8. Stimulus drives Req once per cycle
// and queues the hand-computed outputs expected after the next edge; a
// separate monitor pops and compares on every falling edge.
module tb_rr_arbiter8;

  logic       Clock;
  logic       Resetn;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] GntIdx;
  logic       GntValid;
  logic       TimeoutFlag;

  typedef struct {
    bit         ev;
    logic [2:0] ei;
    bit         ichk;
    bit         et;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_arbiter8 dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Req         (Req),
    .Grant       (Grant),
    .GntIdx      (GntIdx),
    .GntValid    (GntValid),
    .TimeoutFlag (TimeoutFlag)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one cycle of Req and queue the outputs expected after the edge.
  task automatic cyc(input logic [7:0] r, input bit ev, input logic [2:0] ei,
                     input bit et, input string nm);
    exp_t e;
    Req    = r;
    e.ev   = ev;
    e.ei   = ei;
    e.ichk = ev;
    e.et   = et;
    e.name = nm;
    exp_q.push_back(e);
    @(negedge Clock);
  endtask

  task automatic push_reset_exp(input string nm);
    exp_t e;
    e.ev   = 1'b0;
    e.ei   = 3'd0;
    e.ichk = 1'b1;
    e.et   = 1'b0;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Req    = 8'h00;
    push_reset_exp("reset");
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t       e;
    logic [7:0] exp_grant;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_grant = e.ev ? (8'h01 << e.ei) : 8'h00;
        n_checks++;
        if (GntValid !== e.ev || Grant !== exp_grant || TimeoutFlag !== e.et ||
            (e.ichk && GntIdx !== e.ei)) begin
          n_fail++;
          $display("FAIL %s @%0t: got valid=%0b idx=%0d grant=%02h tflag=%0b, expected valid=%0b idx=%0d grant=%02h tflag=%0b",
                   e.name, $time, GntValid, GntIdx, Grant, TimeoutFlag,
                   e.ev, e.ei, exp_grant, e.et);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    Req    = 8'h00;
    @(negedge Clock);
    do_reset();

    // Idle with no requests
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, 3'd0, 1'b0, "idle");

    // Two requesters from Ptr=0: 2 first, then 5 after release
    cyc(8'h24, 1'b1, 3'd2, 1'b0, "pick2");
    cyc(8'h24, 1'b1, 3'd2, 1'b0, "hold2");
    cyc(8'h20, 1'b0, 3'd0, 1'b0, "rel2");
    cyc(8'h20, 1'b0, 3'd0, 1'b0, "idle2");
    cyc(8'h20, 1'b1, 3'd5, 1'b0, "pick5");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "rel5");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "idle5");

    // Full rotation with all requesters active
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) cyc(8'hFF, 1'b1, 3'(k), 1'b0, "rr_hold");
      cyc(8'hFF & ~(8'h01 << k), 1'b0, 3'd0, 1'b0, "rr_rel");
      cyc((k < 7) ? 8'hFF : 8'h81, 1'b0, 3'd0, 1'b0, "rr_gap");
    end

    // Wrap from 7 back to 0, then 7 again
    cyc(8'h81, 1'b1, 3'd0, 1'b0, "wrap0");
    cyc(8'h81, 1'b1, 3'd0, 1'b0, "wrap0h");
    cyc(8'h80, 1'b0, 3'd0, 1'b0, "wrap_rel");
    cyc(8'h80, 1'b0, 3'd0, 1'b0, "wrap_idle");
    cyc(8'h80, 1'b1, 3'd7, 1'b0, "wrap7");
    cyc(8'h80, 1'b1, 3'd7, 1'b0, "wrap7h");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "wrap7_rel");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "wrap7_idle");

    // One-cycle glitch is granted for a single cycle (Ptr becomes 4)
    cyc(8'h08, 1'b1, 3'd3, 1'b0, "glitch");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "glitch_rel");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "glitch_idle");

    // Owner drops while another raises; previous owner cannot win twice
    cyc(8'h02, 1'b1, 3'd1, 1'b0, "own1");
    cyc(8'h02, 1'b1, 3'd1, 1'b0, "own1h");
    cyc(8'h40, 1'b0, 3'd0, 1'b0, "swap_rel");
    cyc(8'h40, 1'b0, 3'd0, 1'b0, "swap_idle");
    cyc(8'h40, 1'b1, 3'd6, 1'b0, "own6");
    cyc(8'h42, 1'b1, 3'd6, 1'b0, "own6_wait1");
    cyc(8'h02, 1'b0, 3'd0, 1'b0, "own6_rel");
    cyc(8'h42, 1'b0, 3'd0, 1'b0, "own6_gap");
    cyc(8'h42, 1'b1, 3'd1, 1'b0, "fair1");
    cyc(8'h40, 1'b0, 3'd0, 1'b0, "fair1_rel");
    cyc(8'h40, 1'b0, 3'd0, 1'b0, "fair1_idle");
    cyc(8'h40, 1'b1, 3'd6, 1'b0, "fair6");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "fair6_rel");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "fair6_idle");

    // Asynchronous reset in the middle of a grant to requester 4
    cyc(8'h10, 1'b1, 3'd4, 1'b0, "own4");
    cyc(8'h10, 1'b1, 3'd4, 1'b0, "own4h");
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    push_reset_exp("async_reset");
    @(negedge Clock);
    Resetn = 1'b1;
    cyc(8'h10, 1'b1, 3'd4, 1'b0, "post_reset4");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "post_rel");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "post_idle");

    // Two requesters held (Ptr=5, so requester 0 wins first)
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc(8'h03, 1'b1, 3'd0, 1'b0, "to_hold0");
    cyc(8'h03, 1'b0, 3'd0, 1'b1, "to_flag0");
    cyc(8'h03, 1'b0, 3'd0, 1'b0, "to_idle0");
    for (int i = 0; i < 16; i++) cyc(8'h03, 1'b1, 3'd1, 1'b0, "to_hold1");
    cyc(8'h03, 1'b0, 3'd0, 1'b1, "to_flag1");
    cyc(8'h03, 1'b0, 3'd0, 1'b0, "to_idle1");
    for (int i = 0; i < 16; i++) cyc(8'h03, 1'b1, 3'd0, 1'b0, "to_hold0b");
    cyc(8'h02, 1'b0, 3'd0, 1'b0, "to_normal_rel");
    cyc(8'h02, 1'b0, 3'd0, 1'b0, "to_normal_idle");
`else
    for (int i = 0; i < 40; i++) cyc(8'h03, 1'b1, 3'd0, 1'b0, "hold_forever");
    cyc(8'h02, 1'b0, 3'd0, 1'b0, "hold_rel");
    cyc(8'h02, 1'b0, 3'd0, 1'b0, "hold_idle");
`endif
    cyc(8'h02, 1'b1, 3'd1, 1'b0, "next1");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "end_rel");
    cyc(8'h00, 1'b0, 3'd0, 1'b0, "end_idle");

    repeat (2) @(negedge Clock);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Picks one requester, drives a 3-bit grant index plus valid, and drives a one-hot grant vector produced by an internal 3-to-8 decoder.
- Holds the grant until the owner drops its request. With the optional timeout, the grant is also released after a fixed number of cycles.
- Sits between requester front-ends and the shared resource's select/enable inputs.

Parameters:
- HOLD_MAX, 16, maximum consecutive GRANT cycles before forced release (timeout build only); legal range 2..256.
- NREQ, 8, requester count; fixed at 8, not overridable.

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous active-low reset
- Req  input  8  Req[i]=1 means requester i wants the resource; held level until done
- Grant  output  8  one-hot; Grant[i]=1 means requester i owns the resource; all zero when no grant
- GntIdx  output  3  binary index of current owner; valid only when GntValid=1
- GntValid  output  1  a grant is active
- TimeoutFlag  output  1  one-cycle pulse on forced release

Behaviour:
- Registered state: State, GntIdx, GntValid, Ptr[2:0] (highest-priority index), HoldCnt (timeout build only).
- Resetn=0, asynchronous and at any time including mid-grant:
  - State=IDLE, GntIdx=0, GntValid=0, Grant=0, Ptr=0, HoldCnt=0, TimeoutFlag=0.
- Grant is combinational: Grant = decode(GntIdx) gated by GntValid.
  - GntIdx=k and GntValid=1 gives Grant[k]=1 and all other bits 0.
- States:
  - IDLE: if Req!=0, select the first set bit scanning Ptr, Ptr+1, ... mod 8 (wraps 7 to 0). Load GntIdx=sel, GntValid=1, go to GRANT. If Req=0, stay in IDLE.
  - GRANT: if Req[GntIdx]=0 at the clock edge, set GntValid=0, Ptr=GntIdx+1 mod 8, go to RELEASE. Otherwise hold.
  - RELEASE: GntValid=0 for exactly one cycle, then go to IDLE unconditionally.
- Latency:
  - Req rising while in IDLE: GntValid/Grant are high in the cycle after the sampling edge (1 cycle).
  - Owner drops Req: grant deasserts after the next edge. The earliest next grant is 2 cycles after that deassertion (RELEASE, then the IDLE decision).
- Simultaneous requests: resolved purely by Ptr order. Requests arriving during GRANT or RELEASE wait and are never lost, because Req is level-held.
- Owner drops Req and another requester raises Req in the same cycle: the owner's release takes effect first. The new requester competes in IDLE.
- Req glitch (1-cycle pulse) seen in IDLE is granted. The grant lasts one GRANT cycle if the request is already low on the next edge.
- Ptr updates only on release, so a requester cannot win twice in a row while another requester is waiting.
- Grant is never multi-hot; GntIdx is stable while GntValid=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - HoldCnt (width clog2(HOLD_MAX)) clears on entering GRANT and increments each GRANT cycle.
  - If HoldCnt==HOLD_MAX-1 and Req[GntIdx] is still 1, force release: GntValid=0, Ptr=GntIdx+1 mod 8, go to RELEASE.
  - TimeoutFlag=1 for that one RELEASE cycle.
  - The grant therefore lasts at most HOLD_MAX cycles.
  - A forcibly released requester that keeps Req high re-competes normally and sits at lowest priority.
  - Normal release in the same cycle as the timeout compare counts as normal release: TimeoutFlag stays 0.
- Undefined: no counter; a grant lasts indefinitely; TimeoutFlag is tied to 0.

Decomposition:
- Package arb_pkg:
  - NREQ=8 and IDXW=3 constants.
  - State enum {IDLE, GRANT, RELEASE}, 2-bit encoding.
- Sub-module grant_decoder: 3-bit index plus enable in, 8-bit one-hot out, bit i set for index i; purely combinational.
- The priority scan stays inline in the arbiter as a rotate, find-first, un-rotate function.

Test Plan:
- Reset, then Req=8'h00 for 10 cycles -> GntValid=0, Grant=8'h00, TimeoutFlag=0 throughout.
- Reset (Ptr=0), Req=8'h24 held -> GntIdx=2, Grant=8'h04. Drop Req[2] -> 1 cycle RELEASE, then GntIdx=5, Grant=8'h20.
- Req=8'hFF held, each owner drops its request after 3 cycles and reasserts it -> grant order 0,1,2,...,7,0. Each grant lasts 3 GRANT cycles with a 2-cycle gap.
- Wrap: after owner 7 releases (Ptr=0), Req=8'h81 -> GntIdx=0, then 7 after release.
- Resetn pulsed low mid-GRANT with GntIdx=4 -> Grant=8'h00 and GntValid=0 immediately (asynchronous). After release of reset with Req=8'h10 -> GntIdx=4 one cycle later.
- ARB_TIMEOUT_EN with HOLD_MAX=16, Req=8'h03 held -> requester 0 granted 16 cycles, TimeoutFlag pulses, then requester 1 granted 16 cycles, alternating. Undefined build: requester 0 holds indefinitely.
